pipe_lane_buffer: RTL
=====================

# pipe_lane_buffer

Parametrised multi-lane pipeline stage register for the dual-issue core. It replaces hand-written per-stage buffers with a single valid/ready stage that carries LANES instruction slots as one bundle. Each lane carries its own valid bit and can be individually squashed to a bubble on entry. The stage provides an optional skid entry so that `in_ready_o` is a registered signal, plus flush and a saturating stall-cycle counter. It is instantiated between adjacent stages: decode/issue, issue/execute, and so on.

## Interface
- `LANES`, 2, number of instruction slots per bundle (≥1).
- `DATA_W`, 32, payload bits per lane (instruction, control, or operand concatenation).
- `SKID`, 1, 1 = two-entry stage with a registered `in_ready_o`; 0 = single entry with a combinational `in_ready_o`.
- `CNT_W`, 16, width of the stall counter.

Ports:
- `clock_i` in 1: single clock; everything is sampled on the rising edge.
- `reset_n_i` in 1: asynchronous active-low reset.
- `flush_i` in 1: synchronous flush of all held bundles.
- `in_valid_i` in 1: an upstream bundle is offered.
- `in_ready_o` out 1: the stage accepts a bundle this cycle.
- `in_lane_vld_i` in LANES: per-lane valid for the offered bundle.
- `in_data_i` in LANES*DATA_W: lane k occupies `[k*DATA_W +: DATA_W]`.
- `kill_i` in LANES: squash lane k of the incoming bundle.
- `out_valid_o` out 1: the held bundle is presented downstream.
- `out_ready_i` in 1: downstream consumes the bundle.
- `out_lane_vld_o` out LANES: per-lane valid of the presented bundle.
- `out_data_o` out LANES*DATA_W: presented payload, same lane packing as the input.
- `stall_cnt_o` out CNT_W: saturating count of downstream stall cycles.

## Operation
- Accept is `in_valid_i && in_ready_o`. Deliver is `out_valid_o && out_ready_i`.
- Entry filtering:
  - The effective lane valid is `in_lane_vld_i & ~kill_i`.
  - A killed or invalid lane is stored with all-zero data and valid 0.
  - If every effective lane valid is 0, the bundle is accepted but not stored (no entry consumed).
- Storage is a main register M, which drives the outputs, plus a skid register S (present only when SKID=1).
- States: EMPTY (M invalid), ONE (M valid, S invalid), FULL (M and S valid; SKID=1 only).
- Transitions, where "in" means a stored accept and "out" means a deliver:
  - EMPTY + in → ONE, M ← in.
  - ONE + in + out → ONE, M ← in.
  - ONE + in, no out → FULL, S ← in (SKID=1). With SKID=0 this case cannot occur, because ready is low.
  - ONE + out, no in → EMPTY.
  - FULL + out → ONE, M ← S.
  - FULL never accepts input.
- `in_ready_o`:
  - SKID=1: a register, high unless the next state is FULL.
  - SKID=0: combinational `!out_valid_o || out_ready_i`.
- Flush:
  - Clears M and S (valid and data to 0) and forces EMPTY.
  - Takes priority over a same-cycle accept or deliver: an accepted input is discarded and a delivered output still counts as consumed.
  - Flush does not alter `stall_cnt_o`.
- Stall counter: increments on each cycle with `out_valid_o && !out_ready_i`, saturates at 2^CNT_W−1, and is cleared only by reset.
- Lane ordering and packing are preserved exactly; lanes never cross.

## Timing
- Reset values (asynchronous assertion, synchronous-safe deassertion by the enclosing reset synchroniser):
  - `out_valid_o`=0, `out_lane_vld_o`=0, `out_data_o`=0, `stall_cnt_o`=0, `in_ready_o`=1.
  - State is EMPTY.
- Latency is one cycle from accept to `out_valid_o` in EMPTY, i.e. a bundle accepted on edge n is presented after edge n.
- Throughput is one bundle per cycle while `out_ready_i`=1.
- SKID=1:
  - `in_ready_o` drops in the cycle after the stage enters FULL and returns high in the cycle after the first deliver from FULL.
  - No bundle is lost or duplicated across the ready drop.
- Outputs are stable while `out_valid_o && !out_ready_i`. Payload must not change under a stall.
- Reset asserted mid-operation empties the stage immediately, with outputs at their reset values within the same cycle.

## Test plan
- **Reset then single bundle:** Release reset, then drive `in_valid_i`=1, lane_vld=2'b11, data={32'hBBBB_0001, 32'hAAAA_0000} for one cycle with `out_ready_i`=1. Required: `out_valid_o`=1 the next cycle with identical data and lane_vld=2'b11, then 0.
- **Downstream stall with SKID=1:** Stream bundles 1..4 with `out_ready_i`=0 from cycle 1. Required: bundles 1 and 2 are held, `in_ready_o`=0 from cycle 3, and `stall_cnt_o` increments each stalled cycle. After `out_ready_i`=1, bundles emerge in order 1, 2, 3, 4 with no gaps or duplicates.
- **Per-lane kill:** Drive lane_vld=2'b11 with kill_i=2'b10. Required: out_lane_vld_o=2'b01 and lane 1 data=0. Then drive kill_i=2'b11: the bundle is accepted, `out_valid_o` stays 0, and nothing is stored.
- **Flush in FULL with simultaneous input:** Reach FULL, then assert `flush_i` with `in_valid_i`=1. Required: the next cycle shows `out_valid_o`=0, `in_ready_o`=1, and the input is discarded; `stall_cnt_o` is unchanged.
- **Counter saturation and SKID=0:** With CNT_W=4, stall for 20 cycles. Required: `stall_cnt_o`=15. With SKID=0, `in_ready_o` follows `out_ready_i` in the same cycle while `out_valid_o`=1.
- **Reset mid-stream:** Assert `reset_n_i` low while in FULL. Required: all outputs are at their reset values immediately, and the first post-reset bundle passes with one-cycle latency.

Source files
------------

// File: rtl/pipe_lane_buffer.sv
// Multi-lane valid/ready pipeline stage register with optional skid entry,
// per-lane squash on entry, flush, and a saturating stall counter.
module pipe_lane_buffer #(
  parameter int LANES  = 2,
  parameter int DATA_W = 32,
  parameter int SKID   = 1,
  parameter int CNT_W  = 16
) (
  input  logic                    clock_i,
  input  logic                    reset_n_i,
  input  logic                    flush_i,
  input  logic                    in_valid_i,
  output logic                    in_ready_o,
  input  logic [LANES-1:0]        in_lane_vld_i,
  input  logic [LANES*DATA_W-1:0] in_data_i,
  input  logic [LANES-1:0]        kill_i,
  output logic                    out_valid_o,
  input  logic                    out_ready_i,
  output logic [LANES-1:0]        out_lane_vld_o,
  output logic [LANES*DATA_W-1:0] out_data_o,
  output logic [CNT_W-1:0]        stall_cnt_o
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } st_e;

  st_e                     state_q, state_d;
  logic [LANES-1:0]        m_vld_q, m_vld_d;
  logic [LANES*DATA_W-1:0] m_data_q, m_data_d;
  logic [LANES-1:0]        s_vld_q, s_vld_d;
  logic [LANES*DATA_W-1:0] s_data_q, s_data_d;
  logic                    rdy_q, rdy_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;

  logic [LANES-1:0]        eff_vld;
  logic [LANES*DATA_W-1:0] eff_data;
  logic                    acc, dlv, put, stall;

  assign out_valid_o    = (state_q != EMPTY);
  assign out_lane_vld_o = m_vld_q;
  assign out_data_o     = m_data_q;
  assign stall_cnt_o    = cnt_q;
  assign in_ready_o     = (SKID != 0) ? rdy_q
                                      : (!out_valid_o || out_ready_i);

  assign eff_vld = in_lane_vld_i & ~kill_i;
  assign acc     = in_valid_i && in_ready_o;
  assign dlv     = out_valid_o && out_ready_i;
  assign put     = acc && (|eff_vld);
  assign stall   = out_valid_o && !out_ready_i;

  // Zero the payload of every killed or invalid lane before storage.
  always_comb begin
    eff_data = '0;
    for (int k = 0; k < LANES; k++) begin
      if (eff_vld[k])
        eff_data[k*DATA_W +: DATA_W] = in_data_i[k*DATA_W +: DATA_W];
    end
  end

  // Next-state for occupancy, main/skid entries, ready and stall counter.
  always_comb begin
    state_d  = state_q;
    m_vld_d  = m_vld_q;
    m_data_d = m_data_q;
    s_vld_d  = s_vld_q;
    s_data_d = s_data_q;
    cnt_d    = cnt_q;
    if (stall && (cnt_q != {CNT_W{1'b1}}))
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    if (flush_i) begin
      state_d  = EMPTY;
      m_vld_d  = '0;
      m_data_d = '0;
      s_vld_d  = '0;
      s_data_d = '0;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (put) begin
            state_d  = ONE;
            m_vld_d  = eff_vld;
            m_data_d = eff_data;
          end
        end
        ONE: begin
          if (put && dlv) begin
            m_vld_d  = eff_vld;
            m_data_d = eff_data;
          end else if (put && (SKID != 0)) begin
            state_d  = FULL;
            s_vld_d  = eff_vld;
            s_data_d = eff_data;
          end else if (dlv) begin
            state_d  = EMPTY;
            m_vld_d  = '0;
            m_data_d = '0;
          end
        end
        FULL: begin
          if (dlv) begin
            state_d  = ONE;
            m_vld_d  = s_vld_q;
            m_data_d = s_data_q;
            s_vld_d  = '0;
            s_data_d = '0;
          end
        end
        default: begin
          state_d = EMPTY;
        end
      endcase
    end
    rdy_d = (state_d != FULL);
  end

  // State and output registers; reset empties the stage at once.
  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q  <= EMPTY;
      m_vld_q  <= '0;
      m_data_q <= '0;
      s_vld_q  <= '0;
      s_data_q <= '0;
      rdy_q    <= 1'b1;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      m_vld_q  <= m_vld_d;
      m_data_q <= m_data_d;
      s_vld_q  <= s_vld_d;
      s_data_q <= s_data_d;
      rdy_q    <= rdy_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule
